rstatus_queue: RTL and testbench
================================

Name: rstatus_queue

Overview:
- Sequential successor to the combinational rstatus decoder.
- Decodes the executing instruction's opcode and ALU op into the standard status code when the ALU, multiplier or divider flags an exception.
- Buffers codes in a parametrised FIFO and drains them, one per cycle, to the register-file writeback port that targets $rstatus.
- Sits between execute and writeback, so back-to-back exceptions are not lost while writeback is busy.

Parameters:
- DATA_W, 32: width of the status word written back.
- DEPTH, 4: FIFO entries. Must be a power of two, 2..16.
- RSTATUS_REG, 30: register index driven on wb_reg.
- MODE, 0: 0 = queue every event; 1 = latest-only. In MODE 1 the single entry is overwritten and nothing is ever dropped.
- DROP_W, 8: width of the saturating drop counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ex_valid  in  1  execute stage holds a valid instruction this cycle.
- op  in  5  instruction opcode.
- alu_op  in  5  ALU op field; meaningful only for R-type.
- exc  in  1  exception flag from ALU, multiplier or divider.
- clear  in  1  synchronous flush of queue and drop counter.
- wb_ready  in  1  writeback port accepts an rstatus write this cycle.
- wb_valid  out  1  head entry available.
- wb_data  out  DATA_W  status code, zero-extended.
- wb_reg  out  5  constant RSTATUS_REG.
- pending  out  log2(DEPTH)+1  entries held.
- full  out  1  pending == DEPTH.
- drop_count  out  DROP_W  events lost to a full queue; saturating.

Behaviour:
- Reset (asynchronous, active-high): queue empty, pointers 0, wb_valid=0, wb_data=0, pending=0, full=0, drop_count=0. Reset wins over everything, including mid-drain; nothing is written back during or after reset until new events arrive.
- Code decode, combinational, in the input cycle:
  - R-type (op=00000) with alu_op 00000 -> 1 (add); 00001 -> 3 (sub); 00110 -> 4 (mult); 00111 -> 5 (div).
  - op=00101 -> 2 (addi).
  - Anything else -> 0.
- Event: ex_valid & exc & code!=0. exc with code 0 is ignored and is not a drop.
- Enqueue: an event at edge N is written to the tail; wb_valid rises after edge N, so latency is 1 cycle. There is no combinational path from inputs to outputs.
- Dequeue: wb_valid & wb_ready at an edge pops the head.
- wb_valid = pending!=0. wb_data = head code, registered storage. Both are stable while wb_ready is low.
- Simultaneous enqueue and dequeue:
  - Legal at any occupancy, including full. The event is accepted, pending is unchanged, full stays high if it was.
  - When empty, the new event is not bypassed to the output: wb_valid=0 in the event's own cycle.
- Full with an event and no dequeue: the event is discarded, drop_count+1, saturating at 2^DROP_W-1. Queue contents are unchanged.
- Pointers wrap modulo DEPTH; order is strictly FIFO.
- MODE 1:
  - One storage entry; an event always overwrites it and sets valid. Dequeue clears valid.
  - If an event and a dequeue coincide, the new event remains valid.
  - drop_count stays 0; full = valid.
- clear:
  - Empties the queue and zeroes drop_count at the edge.
  - Has priority over enqueue and dequeue in the same cycle: a same-cycle event is discarded and not counted.
  - wb_valid is low after the edge.
- pending always equals the number of accepted minus popped entries, and never exceeds DEPTH.

Test Plan:
- Reset, then an add overflow (op=0, alu_op=0, exc=1) with wb_ready=0 -> next cycle wb_valid=1, wb_data=1, wb_reg=30, pending=1. Then wb_ready=1 -> pops, wb_valid=0.
- Four back-to-back events addi, sub, mult, div with wb_ready=0, DEPTH=4 -> full=1; drain yields 2, 3, 4, 5 in order. A fifth event while full -> drop_count=1, contents unchanged.
- Full queue with an event and wb_ready=1 in the same cycle -> pops 2, accepts the new code, pending stays 4, drop_count stays 0.
- exc=1 with op=00011, or R-type alu_op=00010 -> no enqueue, drop_count unchanged. exc=0 with an add -> no enqueue.
- Assert reset asynchronously mid-cycle with 3 entries pending -> outputs clear immediately without a clock edge. clear with a same-cycle event -> empty afterwards, drop_count=0.
- MODE=1: events add then sub on consecutive cycles with wb_ready=0 -> wb_data=3, pending=1, drop_count=0.

Source files
------------

// File: rtl/rstatus_queue_if.sv
// Execute-side event inputs and $rstatus writeback port of the rstatus queue.
interface rstatus_queue_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
);
    localparam int PW = $clog2(DEPTH) + 1;

    logic              ex_valid;
    logic [4:0]        op;
    logic [4:0]        alu_op;
    logic              exc;
    logic              clear;
    logic              wb_ready;
    logic              wb_valid;
    logic [DATA_W-1:0] wb_data;
    logic [4:0]        wb_reg;
    logic [PW-1:0]     pending;
    logic              full;
    logic [DROP_W-1:0] drop_count;

    modport master (
        output ex_valid, op, alu_op, exc, clear, wb_ready,
        input  wb_valid, wb_data, wb_reg, pending, full, drop_count
    );

    modport slave (
        input  ex_valid, op, alu_op, exc, clear, wb_ready,
        output wb_valid, wb_data, wb_reg, pending, full, drop_count
    );
endinterface

// File: rtl/rstatus_queue.sv
// Decodes ALU/mult/div exceptions into $rstatus codes and queues them
// for the register-file writeback port, one write per cycle.
module rstatus_queue #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 4,
    parameter int RSTATUS_REG = 30,
    parameter int MODE        = 0,
    parameter int DROP_W      = 8
) (
    input  logic            clock,
    input  logic            reset,
    rstatus_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [2:0]        code;
    logic              evt;
    logic [PW-1:0]     count;
    logic [2:0]        head_code;
    logic [DROP_W-1:0] drops;

    // Status code of the instruction in execute; 0 means "no status"
    always_comb begin
        code = 3'd0;
        if (bus.op == 5'b00101) begin
            code = 3'd2;
        end else if (bus.op == 5'b00000) begin
            case (bus.alu_op)
                5'b00000: code = 3'd1;
                5'b00001: code = 3'd3;
                5'b00110: code = 3'd4;
                5'b00111: code = 3'd5;
                default:  code = 3'd0;
            endcase
        end
    end

    // An exception whose instruction has no status code is not an event
    assign evt = bus.ex_valid & bus.exc & (code != 3'd0);

    generate
        if (MODE == 1) begin : g_latest
            logic       valid_q;
            logic [2:0] code_q;

            // Single entry: newest event overwrites, a pop only clears it
            // when no event arrives in the same cycle
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    valid_q <= 1'b0;
                    code_q  <= 3'd0;
                end else if (bus.clear) begin
                    valid_q <= 1'b0;
                end else if (evt) begin
                    valid_q <= 1'b1;
                    code_q  <= code;
                end else if (valid_q && bus.wb_ready) begin
                    valid_q <= 1'b0;
                end
            end

            assign count     = PW'(valid_q);
            assign head_code = code_q;
            assign drops     = '0;
        end else begin : g_fifo
            logic [2:0]        mem [DEPTH];
            logic [AW-1:0]     rd_ptr;
            logic [AW-1:0]     wr_ptr;
            logic [PW-1:0]     cnt;
            logic [DROP_W-1:0] drop_q;
            logic              deq;
            logic              is_full;
            logic              enq;

            // A pop frees a slot in the same cycle, so a full queue still
            // accepts an event when the head is being written back
            assign deq     = (cnt != '0) & bus.wb_ready;
            assign is_full = (cnt == PW'(DEPTH));
            assign enq     = evt & (~is_full | deq);

            // Code storage; contents only matter where cnt says they are live
            always_ff @(posedge clock) begin
                if (enq && !bus.clear)
                    mem[wr_ptr] <= code;
            end

            // Pointers and occupancy; clear outranks push and pop
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    rd_ptr <= '0;
                    wr_ptr <= '0;
                    cnt    <= '0;
                end else if (bus.clear) begin
                    rd_ptr <= '0;
                    wr_ptr <= '0;
                    cnt    <= '0;
                end else begin
                    if (enq) wr_ptr <= wr_ptr + AW'(1);
                    if (deq) rd_ptr <= rd_ptr + AW'(1);
                    case ({enq, deq})
                        2'b10:   cnt <= cnt + PW'(1);
                        2'b01:   cnt <= cnt - PW'(1);
                        default: cnt <= cnt;
                    endcase
                end
            end

            // Saturating count of events lost to a full, non-draining queue
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    drop_q <= '0;
                end else if (bus.clear) begin
                    drop_q <= '0;
                end else if (evt && is_full && !deq && drop_q != '1) begin
                    drop_q <= drop_q + DROP_W'(1);
                end
            end

            assign count     = cnt;
            assign head_code = mem[rd_ptr];
            assign drops     = drop_q;
        end
    endgenerate

    // Outputs come straight from state; data is forced to 0 when empty so
    // stale storage never shows on the port
    assign bus.wb_valid   = (count != '0);
    assign bus.wb_data    = bus.wb_valid ? DATA_W'(head_code) : '0;
    assign bus.wb_reg     = 5'(RSTATUS_REG);
    assign bus.pending    = count;
    assign bus.full       = (MODE == 1) ? bus.wb_valid : (count == PW'(DEPTH));
    assign bus.drop_count = drops;
endmodule

// File: tb/tb_rstatus_queue.sv
// Directed bench for rstatus_queue: a FIFO-mode and a latest-only instance
// share stimulus; a queue model is compared every cycle, plus literal checks.
module tb_rstatus_queue;
    localparam int DEPTH  = 4;
    localparam int DROP_W = 8;
    localparam int DATA_W = 32;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ex_valid = 1'b0;
    logic [4:0] op = 5'd0;
    logic [4:0] alu_op = 5'd0;
    logic       exc = 1'b0;
    logic       clear = 1'b0;
    logic       wb_ready = 1'b0;

    always #5 clock = ~clock;

    rstatus_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) if0 ();
    rstatus_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) if1 ();

    assign if0.ex_valid = ex_valid;
    assign if0.op       = op;
    assign if0.alu_op   = alu_op;
    assign if0.exc      = exc;
    assign if0.clear    = clear;
    assign if0.wb_ready = wb_ready;
    assign if1.ex_valid = ex_valid;
    assign if1.op       = op;
    assign if1.alu_op   = alu_op;
    assign if1.exc      = exc;
    assign if1.clear    = clear;
    assign if1.wb_ready = wb_ready;

    rstatus_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RSTATUS_REG(30), .MODE(0), .DROP_W(DROP_W))
        u_fifo (.clock(clock), .reset(reset), .bus(if0));
    rstatus_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RSTATUS_REG(30), .MODE(1), .DROP_W(DROP_W))
        u_latest (.clock(clock), .reset(reset), .bus(if1));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int decode(input logic [4:0] o, input logic [4:0] a);
        if (o == 5'd5) return 2;
        if (o == 5'd0) begin
            if (a == 5'd0) return 1;
            if (a == 5'd1) return 3;
            if (a == 5'd6) return 4;
            if (a == 5'd7) return 5;
        end
        return 0;
    endfunction

    // Reference behaviour: a plain queue for FIFO mode, one slot for latest-only
    int q[$];
    int mdrop = 0;
    bit m1v = 0;
    int m1d = 0;

    always @(posedge clock or posedge reset) begin
        if (reset || clear) begin
            q.delete();
            mdrop = 0;
            m1v = 0;
        end else begin
            int  c;
            bit  ev;
            bit  d1;
            c  = decode(op, alu_op);
            ev = ex_valid && exc && c != 0;
            if (q.size() != 0 && wb_ready) void'(q.pop_front());
            if (ev) begin
                if (q.size() < DEPTH) q.push_back(c);
                else if (mdrop < (2 ** DROP_W) - 1) mdrop++;
            end
            d1 = m1v && wb_ready;
            if (ev) begin
                m1v = 1;
                m1d = c;
            end else if (d1) begin
                m1v = 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clock) begin
        if (!reset) begin
            chk("q_valid", if0.wb_valid, q.size() != 0);
            chk("q_pending", if0.pending, q.size());
            chk("q_full", if0.full, q.size() == DEPTH);
            chk("q_drop", if0.drop_count, mdrop);
            chk("q_reg", if0.wb_reg, 30);
            if (q.size() != 0) chk("q_data", if0.wb_data, q[0]);
            chk("l_valid", if1.wb_valid, m1v);
            chk("l_pending", if1.pending, m1v);
            chk("l_full", if1.full, m1v);
            chk("l_drop", if1.drop_count, 0);
            if (m1v) chk("l_data", if1.wb_data, m1d);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic ev(input logic [4:0] o, input logic [4:0] a);
        ex_valid = 1'b1;
        exc = 1'b1;
        op = o;
        alu_op = a;
    endtask

    task automatic idle();
        ex_valid = 1'b0;
        exc = 1'b0;
        op = 5'd0;
        alu_op = 5'd0;
    endtask

    initial begin
        int exp_drain[4];
        exp_drain = '{3, 4, 5, 1};

        // reset state
        repeat (2) step();
        chk("rst_valid", if0.wb_valid, 0);
        chk("rst_data", if0.wb_data, 0);
        chk("rst_pending", if0.pending, 0);
        chk("rst_full", if0.full, 0);
        chk("rst_drop", if0.drop_count, 0);
        reset = 1'b0;
        step();

        // single add overflow, one-cycle latency, then pop
        ev(5'd0, 5'd0);
        step();
        idle();
        chk("add_valid", if0.wb_valid, 1);
        chk("add_data", if0.wb_data, 1);
        chk("add_reg", if0.wb_reg, 30);
        chk("add_pending", if0.pending, 1);
        wb_ready = 1'b1;
        step();
        chk("add_popped", if0.wb_valid, 0);
        wb_ready = 1'b0;

        // fill with addi, sub, mult, div; fifth event is dropped
        ev(5'd5, 5'd0); step();
        ev(5'd0, 5'd1); step();
        ev(5'd0, 5'd6); step();
        ev(5'd0, 5'd7); step();
        chk("fill_full", if0.full, 1);
        chk("fill_pending", if0.pending, 4);
        ev(5'd0, 5'd0); step();
        chk("drop_one", if0.drop_count, 1);
        chk("drop_head", if0.wb_data, 2);
        chk("drop_pending", if0.pending, 4);

        // full queue: push and pop together
        wb_ready = 1'b1;
        ev(5'd0, 5'd0); step();
        idle();
        chk("pp_pending", if0.pending, 4);
        chk("pp_full", if0.full, 1);
        chk("pp_drop", if0.drop_count, 1);
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", if0.wb_data, exp_drain[i]);
            step();
        end
        chk("drain_empty", if0.wb_valid, 0);
        wb_ready = 1'b0;

        // non-events
        ev(5'd3, 5'd0); step();
        ev(5'd0, 5'd2); step();
        ev(5'd0, 5'd0); exc = 1'b0; step();
        idle();
        chk("nonevt_pending", if0.pending, 0);
        chk("nonevt_drop", if0.drop_count, 1);

        // clear beats a same-cycle event and zeroes drops
        ev(5'd0, 5'd0); step();
        clear = 1'b1;
        ev(5'd5, 5'd0); step();
        clear = 1'b0;
        idle();
        chk("clr_valid", if0.wb_valid, 0);
        chk("clr_pending", if0.pending, 0);
        chk("clr_drop", if0.drop_count, 0);
        step();
        chk("clr_stays", if0.wb_valid, 0);

        // drop counter saturation
        for (int i = 0; i < 4 + 260; i++) begin
            ev(5'd0, 5'd1);
            step();
        end
        idle();
        chk("sat_drop", if0.drop_count, 255);
        chk("sat_head", if0.wb_data, 3);
        clear = 1'b1; step(); clear = 1'b0;
        chk("sat_clr", if0.drop_count, 0);

        // asynchronous reset mid-cycle with 3 entries pending
        ev(5'd0, 5'd0); step();
        ev(5'd0, 5'd6); step();
        ev(5'd0, 5'd7); step();
        idle();
        chk("ar_pending_pre", if0.pending, 3);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid", if0.wb_valid, 0);
        chk("ar_pending", if0.pending, 0);
        chk("ar_data", if0.wb_data, 0);
        chk("ar_l_valid", if1.wb_valid, 0);
        step();
        reset = 1'b0;
        step();
        chk("ar_after", if0.wb_valid, 0);

        // latest-only: add then sub keeps only sub
        ev(5'd0, 5'd0); step();
        ev(5'd0, 5'd1); step();
        idle();
        chk("l_data_sub", if1.wb_data, 3);
        chk("l_pending1", if1.pending, 1);
        chk("l_drop0", if1.drop_count, 0);
        chk("l_full1", if1.full, 1);
        chk("q_pending2", if0.pending, 2);
        wb_ready = 1'b1;
        ev(5'd5, 5'd0); step();
        idle();
        chk("l_coinc_valid", if1.wb_valid, 1);
        chk("l_coinc_data", if1.wb_data, 2);
        chk("q_coinc_pending", if0.pending, 2);
        step();
        chk("l_popped", if1.wb_valid, 0);
        step();
        chk("q_drained", if0.wb_valid, 0);
        wb_ready = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
